// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system bus: arbiter states, address map and master ids.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_e;

    localparam logic [15:0] S0_BASE  = 16'h0000;
    localparam logic [15:0] S0_LIMIT = 16'h0800;
    localparam logic [15:0] S1_BASE  = 16'h7000;
    localparam logic [15:0] S1_LIMIT = 16'h7200;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/bus_addr_dec.sv
// Slave-select decoder for the system bus; selects are only raised while some master owns the bus.
module bus_addr_dec
    import bus_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] S0_BASE  = ADDR_W'(bus_pkg::S0_BASE),
    parameter logic [ADDR_W-1:0] S0_LIMIT = ADDR_W'(bus_pkg::S0_LIMIT),
    parameter logic [ADDR_W-1:0] S1_BASE  = ADDR_W'(bus_pkg::S1_BASE),
    parameter logic [ADDR_W-1:0] S1_LIMIT = ADDR_W'(bus_pkg::S1_LIMIT)
) (
    input  logic [ADDR_W-1:0] s_addr,
    input  logic              grant_active,
    output logic              s0_sel,
    output logic              s1_sel
);

    localparam logic [ADDR_W-1:0] S0_SIZE = S0_LIMIT - S0_BASE;
    localparam logic [ADDR_W-1:0] S1_SIZE = S1_LIMIT - S1_BASE;

    logic [ADDR_W-1:0] s0_off;
    logic [ADDR_W-1:0] s1_off;

    // Unsigned offset compare covers base <= addr < limit in one test per window.
    assign s0_off = s_addr - S0_BASE;
    assign s1_off = s_addr - S1_BASE;

    assign s0_sel = grant_active && (s0_off < S0_SIZE);
    assign s1_sel = grant_active && (s1_off < S1_SIZE);

endmodule

// File: rtl/bus_arbiter_2m.sv
// Round-robin two-master arbiter with shared-bus mux and one-cycle read return.
// Define BUS_ARB_PREEMPT_EN to bound a grant to MAX_HOLD cycles while the other master waits.
module bus_arbiter_2m
    import bus_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 64,
    parameter int                MAX_HOLD = 8,
    parameter logic [ADDR_W-1:0] S0_BASE  = ADDR_W'(bus_pkg::S0_BASE),
    parameter logic [ADDR_W-1:0] S0_LIMIT = ADDR_W'(bus_pkg::S0_LIMIT),
    parameter logic [ADDR_W-1:0] S1_BASE  = ADDR_W'(bus_pkg::S1_BASE),
    parameter logic [ADDR_W-1:0] S1_LIMIT = ADDR_W'(bus_pkg::S1_LIMIT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_wr,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic [DATA_W-1:0] m1_dout,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m0_din,
    output logic [DATA_W-1:0] m1_din,
    output logic              s_wr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_din,
    output logic              s0_sel,
    output logic              s1_sel
);

    arb_state_e        state_q, state_d;
    logic              last_pri_q, last_pri_d;
    logic [1:0]        sel_q;
    logic              mid_q;
    logic              preempt0, preempt1;
    logic [DATA_W-1:0] rd_data;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_out_of_range
        // An 8-bit hold counter cannot express this bound; such builds are unsupported.
    end

`ifdef BUS_ARB_PREEMPT_EN
    logic [7:0] hold_q, hold_d;
    logic       hold_last;

    assign hold_last = (hold_q == 8'(MAX_HOLD - 1));
    assign preempt0  = m1_req && hold_last;
    assign preempt1  = m0_req && hold_last;
`else
    assign preempt0 = 1'b0;
    assign preempt1 = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_pri_d = last_pri_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req && m1_req) state_d = (last_pri_q == M1) ? G0 : G1;
                else if (m0_req)      state_d = G0;
                else if (m1_req)      state_d = G1;
            end
            G0: begin
                if (m0_req && !preempt0) state_d = G0;
                else if (m1_req)         state_d = G1;
                else                     state_d = IDLE;
            end
            G1: begin
                if (m1_req && !preempt1) state_d = G1;
                else if (m0_req)         state_d = G0;
                else                     state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            if (state_d == G0) last_pri_d = M0;
            if (state_d == G1) last_pri_d = M1;
        end
    end

`ifdef BUS_ARB_PREEMPT_EN
    // The count only advances while the other master is actually waiting.
    always_comb begin
        hold_d = hold_q;
        if (state_d != state_q) begin
            hold_d = 8'd0;
        end else if (((state_q == G0 && m1_req) || (state_q == G1 && m0_req)) && !hold_last) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold_q <= 8'd0;
        else       hold_q <= hold_d;
    end
`endif

    assign m0_grant = (state_q == G0);
    assign m1_grant = (state_q == G1);

    always_comb begin
        s_wr   = 1'b0;
        s_addr = '0;
        s_din  = '0;
        if (m0_grant) begin
            s_wr   = m0_wr;
            s_addr = m0_addr;
            s_din  = m0_dout;
        end else if (m1_grant) begin
            s_wr   = m1_wr;
            s_addr = m1_addr;
            s_din  = m1_dout;
        end
    end

    bus_addr_dec #(
        .ADDR_W   (ADDR_W),
        .S0_BASE  (S0_BASE),
        .S0_LIMIT (S0_LIMIT),
        .S1_BASE  (S1_BASE),
        .S1_LIMIT (S1_LIMIT)
    ) u_addr_dec (
        .s_addr       (s_addr),
        .grant_active (m0_grant || m1_grant),
        .s0_sel       (s0_sel),
        .s1_sel       (s1_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_pri_q <= M1;
            sel_q      <= 2'b00;
            mid_q      <= M0;
        end else begin
            state_q    <= state_d;
            last_pri_q <= last_pri_d;
            sel_q      <= {s0_sel, s1_sel};
            mid_q      <= m1_grant ? M1 : M0;
        end
    end

    // Read data follows the master that owned the bus last cycle, even if the grant has moved.
    always_comb begin
        rd_data = '0;
        if (sel_q[1])      rd_data = s0_dout;
        else if (sel_q[0]) rd_data = s1_dout;
        m0_din = '0;
        m1_din = '0;
        if (mid_q == M0) m0_din = rd_data;
        else             m1_din = rd_data;
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Scoreboard bench for bus_arbiter_2m: directed scenarios followed by randomized traffic.
module tb_bus_arbiter_2m;

    localparam int AW       = 16;
    localparam int DW       = 64;
    localparam int MAX_HOLD = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m1_req = 1'b0, m0_wr = 1'b0, m1_wr = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_dout = '0, m1_dout = '0, s0_dout = '0, s1_dout = '0;
    logic          m0_grant, m1_grant, s_wr, s0_sel, s1_sel;
    logic [DW-1:0] m0_din, m1_din, s_din;
    logic [AW-1:0] s_addr;

    bus_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
        .s0_dout(s0_dout), .s1_dout(s1_dout),
        .m0_grant(m0_grant), .m1_grant(m1_grant), .m0_din(m0_din), .m1_din(m1_din),
        .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din), .s0_sel(s0_sel), .s1_sel(s1_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          g0, g1, swr, sel0, sel1;
        logic [AW-1:0] saddr;
        logic [DW-1:0] sdin, d0, d1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   stim_done = 0;
    int   cyc_no = 0;

    // Reference model: owner -1 = nobody, otherwise master index.
    int owner, last_srv, hold, prev_m, prev_s;

    function automatic int slave_of(input logic [AW-1:0] a);
        if (a < 16'h0800) return 0;
        if (a >= 16'h7000 && a < 16'h7200) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1; last_srv = 1; hold = 0; prev_m = -1; prev_s = -1;
    endtask

    task automatic model_step();
        bit req[2];
        int nxt, other;
        if (reset) begin
            model_reset();
            return;
        end
        req[0] = m0_req; req[1] = m1_req;
        prev_m = owner;
        prev_s = (owner < 0) ? -1 : slave_of(owner == 0 ? m0_addr : m1_addr);
        if (owner < 0) begin
            if (req[0] && req[1]) nxt = 1 - last_srv;
            else if (req[0])      nxt = 0;
            else if (req[1])      nxt = 1;
            else                  nxt = -1;
        end else begin
            other = 1 - owner;
            if (req[owner]) begin
                nxt = owner;
`ifdef BUS_ARB_PREEMPT_EN
                if (req[other] && hold == MAX_HOLD - 1) nxt = other;
`endif
            end else begin
                nxt = req[other] ? other : -1;
            end
            if (nxt == owner && req[other] && hold < MAX_HOLD - 1) hold = hold + 1;
        end
        if (nxt != owner) begin
            hold = 0;
            if (nxt >= 0) last_srv = nxt;
        end
        owner = nxt;
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        int   s;
        e.cyc = cyc_no;
        e.g0 = (owner == 0); e.g1 = (owner == 1);
        e.swr = 1'b0; e.saddr = '0; e.sdin = '0;
        if (owner == 0) begin e.swr = m0_wr; e.saddr = m0_addr; e.sdin = m0_dout; end
        if (owner == 1) begin e.swr = m1_wr; e.saddr = m1_addr; e.sdin = m1_dout; end
        s = (owner < 0) ? -1 : slave_of(e.saddr);
        e.sel0 = (s == 0); e.sel1 = (s == 1);
        e.d0 = '0; e.d1 = '0;
        if (prev_s == 0 && prev_m == 0) e.d0 = s0_dout;
        if (prev_s == 1 && prev_m == 0) e.d0 = s1_dout;
        if (prev_s == 0 && prev_m == 1) e.d1 = s0_dout;
        if (prev_s == 1 && prev_m == 1) e.d1 = s1_dout;
        return e;
    endfunction

    task automatic cycle(input logic rst, input logic r0, input logic r1, input logic w0,
                         input logic w1, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        @(negedge clk);
        reset = rst; m0_req = r0; m1_req = r1; m0_wr = w0; m1_wr = w1;
        m0_addr = a0; m1_addr = a1;
        m0_dout = {$urandom, $urandom}; m1_dout = {$urandom, $urandom};
        s0_dout = {$urandom, $urandom}; s1_dout = {$urandom, $urandom};
        if (rst) model_reset();
        #1;
        exp_q.push_back(model_outputs());
        cyc_no++;
        @(posedge clk);
        model_step();
    endtask

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] tbl [7];
        tbl = '{16'h0000, 16'h07FF, 16'h0800, 16'h6FFF, 16'h7000, 16'h71FF, 16'h7200};
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return tbl[$urandom_range(0, 6)];
    endfunction

    task automatic chk(input string name, input int c, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, c, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0) begin
                if (stim_done) break;
                continue;
            end
            e = exp_q.pop_front();
            $display("cyc %0d rst=%b req=%b%b grant=%b%b wr=%b addr=%h sel=%b%b d0=%h d1=%h",
                     e.cyc, reset, m0_req, m1_req, m0_grant, m1_grant, s_wr, s_addr,
                     s0_sel, s1_sel, m0_din, m1_din);
            chk("m0_grant", e.cyc, DW'(m0_grant), DW'(e.g0));
            chk("m1_grant", e.cyc, DW'(m1_grant), DW'(e.g1));
            chk("s_wr",     e.cyc, DW'(s_wr),     DW'(e.swr));
            chk("s_addr",   e.cyc, DW'(s_addr),   DW'(e.saddr));
            chk("s_din",    e.cyc, s_din,         e.sdin);
            chk("s0_sel",   e.cyc, DW'(s0_sel),   DW'(e.sel0));
            chk("s1_sel",   e.cyc, DW'(s1_sel),   DW'(e.sel1));
            chk("m0_din",   e.cyc, m0_din,        e.d0);
            chk("m1_din",   e.cyc, m1_din,        e.d1);
        end
    endtask

    task automatic stimulus();
        logic r0, r1, rst;
        model_reset();
        cycle(1, 0, 0, 0, 0, 16'h0, 16'h0);
        cycle(1, 1, 1, 0, 0, 16'h0, 16'h0);
        cycle(0, 0, 0, 0, 0, 16'h0, 16'h0);
        // m0 reads the top of s0, then the first unmapped word, then reset lands mid-grant.
        cycle(0, 1, 0, 0, 0, 16'h07FF, 16'h0);
        cycle(0, 1, 0, 0, 0, 16'h07FF, 16'h0);
        cycle(0, 1, 0, 0, 0, 16'h0800, 16'h0);
        cycle(0, 1, 0, 0, 0, 16'h0100, 16'h0);
        cycle(1, 1, 0, 0, 0, 16'h0100, 16'h0);
        cycle(0, 1, 1, 0, 0, 16'h0010, 16'h7010);
        // Round robin: both request, m0 drops, m1 drops, both re-request.
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 1, 16'h0020, 16'h7000);
        cycle(0, 0, 1, 0, 1, 16'h0020, 16'h7000);
        cycle(0, 0, 1, 1, 1, 16'h0020, 16'h71FF);
        cycle(0, 0, 1, 0, 1, 16'h0020, 16'h7200);
        cycle(0, 0, 0, 0, 0, 16'h0020, 16'h7200);
        cycle(0, 1, 1, 0, 0, 16'h0030, 16'h7040);
        cycle(0, 1, 1, 0, 0, 16'h0030, 16'h7040);
        // Handover read: m0 reads s1 on its final grant cycle while m1 waits.
        cycle(0, 1, 1, 0, 0, 16'h7100, 16'h0040);
        cycle(0, 0, 1, 0, 0, 16'h7100, 16'h0040);
        cycle(0, 0, 1, 0, 0, 16'h7100, 16'h0040);
        cycle(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        // m0 holds the bus while m1 keeps requesting.
        cycle(0, 1, 0, 0, 0, 16'h0050, 16'h0060);
        for (int i = 0; i < 14; i++) cycle(0, 1, 1, 0, 0, 16'h0050, 16'h0060);
        cycle(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        r0 = 0; r1 = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r0 = ~r0;
            if ($urandom_range(0, 3) == 0) r1 = ~r1;
            rst = ($urandom_range(0, 99) == 0);
            cycle(rst, r0, r1, 1'($urandom), 1'($urandom), pick_addr(), pick_addr());
        end
        stim_done = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            stimulus();
            monitor();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Two-master arbiter and master-side mux for the shared system bus.
- Masters: m0 (CPU) and m1 (DMA). Slaves: s0 (memory, 0x0000-0x07FF) and s1 (peripheral, 0x7000-0x71FF).
- Grants the bus round-robin, with optional bounded hold, and drives the shared s_* lines from the granted master.
- Decodes slave selects and returns one-cycle-latency read data to the master that issued the access.

Parameters:
- ADDR_W, 16, bus address width.
- DATA_W, 64, bus data width.
- MAX_HOLD, 8, max consecutive grant cycles while the other master waits (preempt build only; legal range 2..255).
- S0_BASE / S0_LIMIT, 16'h0000 / 16'h0800, s0 window (base inclusive, limit exclusive).
- S1_BASE / S1_LIMIT, 16'h7000 / 16'h7200, s1 window (base inclusive, limit exclusive).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  bus request, held high for the whole access sequence.
- m0_wr, m1_wr  in  1  write strobe (1 = write).
- m0_addr, m1_addr  in  ADDR_W  master address.
- m0_dout, m1_dout  in  DATA_W  master write data.
- s0_dout, s1_dout  in  DATA_W  slave read data.
- m0_grant, m1_grant  out  1  grant; one-hot or zero.
- m0_din, m1_din  out  DATA_W  read data back to each master.
- s_wr  out  1  shared write strobe.
- s_addr  out  ADDR_W  shared address.
- s_din  out  DATA_W  shared write data.
- s0_sel, s1_sel  out  1  slave selects.

Behaviour:
- FSM states: IDLE, G0, G1. Registered state; grants are a Moore decode (G0 -> m0_grant=1, G1 -> m1_grant=1). Request-to-grant latency is 1 cycle.
- last_pri register records the last master served. Reset value = 1, so m0 wins the first tie.
- IDLE transitions:
  - Only one master requesting -> that master's grant state.
  - Both requesting -> the master != last_pri.
  - Neither requesting -> stay in IDLE.
- G0 transitions (G1 symmetric):
  - m0_req=1 and no preemption -> stay.
  - m0_req=0 and m1_req=1 -> G1 directly, with no idle cycle.
  - m0_req=0 and m1_req=0 -> IDLE.
- last_pri updates on every entry into G0/G1.
- Shared bus lines:
  - In G0/G1, s_wr/s_addr/s_din = the granted master's wr/addr/dout (combinational).
  - In IDLE they are driven to 0 (never X).
- Slave select decode is combinational on s_addr, and active only when a grant is active:
  - S0_BASE <= s_addr < S0_LIMIT -> s0_sel=1.
  - S1_BASE <= s_addr < S1_LIMIT -> s1_sel=1.
  - Otherwise both 0, including unmapped addresses and IDLE.
  - Never both 1.
- Read return:
  - Register {s0_sel, s1_sel} and the granted master id each cycle.
  - Next cycle, the selected slave's dout is routed to that master's din.
  - The other master's din = 0. Unmapped address or no grant in the previous cycle -> both din = 0.
  - A read issued on the last cycle of a grant still returns to the issuing master, even after the grant has moved.
- Reset: async assert forces state=IDLE, last_pri=1, registered sel=00, hold count=0.
  - All outputs read 0 while reset is held, including mid-access.
  - First grant is possible at the first clock edge after deassertion.
- Simultaneous events: m1_req rising in the same cycle m0_req falls while in G0 -> G1 next cycle.

Optional Feature:
- Macro: BUS_ARB_PREEMPT_EN.
- Defined:
  - hold_cnt counts cycles in the current grant state; it clears on any state change.
  - In G0, if m1_req=1 and hold_cnt == MAX_HOLD-1 -> G1 at the next edge, even if m0_req is still 1.
  - The preempted master re-arbitrates normally.
  - hold_cnt saturates at MAX_HOLD-1 and does not advance while the other master is idle.
- Undefined: no counter exists; a grant holds until its master drops req, and there is no starvation bound.

Decomposition:
- Package bus_pkg:
  - FSM state encodings IDLE/G0/G1.
  - Address-map constants S0_BASE, S0_LIMIT, S1_BASE, S1_LIMIT.
  - Master id constants M0 = 1'b0, M1 = 1'b1.
- One sub-module: bus_addr_dec (s_addr + grant_active -> s0_sel, s1_sel). It is shared with any future single-master bus variant.

Test Plan:
- Reset mid-grant: assert reset while in G0 -> grants=0, s_*=0, sels=00 immediately. After release, m0_req=m1_req=1 -> m0_grant=1 one cycle later.
- Round-robin: both requesting. m0 drops req after 3 cycles -> m1_grant=1 next cycle. m1 drops req and both re-request -> m0_grant.
- Decode/read: m0 reads 0x07FF -> s0_sel=1; s0_dout=64'hA5A5 appears on m0_din next cycle, m1_din=0. Address 0x0800 -> sels=00, m0_din=0 next cycle.
- s1 window: m1 writes 0x7000 and 0x71FF -> s1_sel=1, s_wr=1, s_din=m1_dout. Address 0x7200 -> sels=00.
- Handover read: m0 reads 0x7100 on its last grant cycle while m1 takes over -> s1_dout returns on m0_din; m1_din=0.
- Preempt (BUS_ARB_PREEMPT_EN, MAX_HOLD=8): m0_req held and m1_req raised -> m1_grant asserts exactly 8 cycles after m1_req rises. Same stimulus without the macro -> m0 keeps the grant indefinitely.
